// File: rtl/csi_quad_line_scheduler.sv
// Round-robin line scheduler: shares one frame-buffer burst-write port among four
// CSI channel line FIFOs, tracking per-channel line index/address and overflow.
module csi_quad_line_scheduler #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       LEN_W       = 16,
  parameter int unsigned       LINE_WORDS  = 480,
  parameter int unsigned       LINES       = 1080,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] CH_STRIDE   = 32'h0080_0000,
  parameter logic [ADDR_W-1:0] LINE_STRIDE = 32'h0000_0800
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_enable,
  input  logic [3:0]        I_frame_start,
  input  logic [3:0]        I_line_rdy,
  output logic [3:0]        O_line_pop,
  output logic              O_cmd_valid,
  input  logic              I_cmd_ready,
  output logic [1:0]        O_cmd_ch,
  output logic [ADDR_W-1:0] O_cmd_addr,
  output logic [LEN_W-1:0]  O_cmd_len,
  input  logic              I_cmd_done,
  output logic              O_busy,
  output logic [3:0]        O_ovf
);

  localparam int unsigned IDX_W = $clog2(LINES + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POP  = 3'd3;
  localparam logic [2:0] S_SKIP = 3'd4;

  logic [2:0]        r_state;
  logic [1:0]        r_rr_ptr;
  logic [1:0]        r_ch;
  logic [ADDR_W-1:0] r_addr;
  logic              r_stale;
  logic [IDX_W-1:0]  r_line_idx  [4];
  logic [ADDR_W-1:0] r_line_addr [4];
  logic [3:0]        r_ovf;

  logic              w_grant_vld;
  logic [1:0]        w_grant_ch;
  logic [IDX_W-1:0]  w_eff_idx;
  logic [ADDR_W-1:0] w_eff_addr;

  function automatic logic [ADDR_W-1:0] f_ch_base(input logic [1:0] ch);
    return BASE_ADDR + CH_STRIDE * ADDR_W'(ch);
  endfunction

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_ch  = r_rr_ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!w_grant_vld && I_line_rdy[r_rr_ptr + 2'(i)]) begin
        w_grant_vld = 1'b1;
        w_grant_ch  = r_rr_ptr + 2'(i);
      end
    end
  end

  // A frame start landing on the grant cycle already belongs to the new frame.
  always_comb begin
    w_eff_idx  = r_line_idx[w_grant_ch];
    w_eff_addr = r_line_addr[w_grant_ch];
    if (I_frame_start[w_grant_ch]) begin
      w_eff_idx  = '0;
      w_eff_addr = f_ch_base(w_grant_ch);
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_ch     <= '0;
      r_addr   <= '0;
      r_stale  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (I_enable && w_grant_vld) begin
            r_ch    <= w_grant_ch;
            r_addr  <= w_eff_addr;
            r_stale <= 1'b0;
            r_state <= (w_eff_idx < IDX_W'(LINES)) ? S_CMD : S_SKIP;
          end
        end
        S_CMD: begin
          if (I_frame_start[r_ch]) r_stale <= 1'b1;
          if (I_cmd_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (I_frame_start[r_ch]) r_stale <= 1'b1;
          if (I_cmd_done) r_state <= S_POP;
        end
        S_POP, S_SKIP: begin
          r_rr_ptr <= r_ch + 2'd1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A line whose frame was restarted while in flight must not advance the new frame.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int unsigned n = 0; n < 4; n++) begin
        r_line_idx[n]  <= '0;
        r_line_addr[n] <= f_ch_base(2'(n));
      end
      r_ovf <= '0;
    end else begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (I_frame_start[n]) begin
          r_line_idx[n]  <= '0;
          r_line_addr[n] <= f_ch_base(2'(n));
          r_ovf[n]       <= 1'b0;
        end else if (r_state == S_POP && r_ch == 2'(n) && !r_stale) begin
          r_line_idx[n]  <= r_line_idx[n] + IDX_W'(1);
          r_line_addr[n] <= r_line_addr[n] + LINE_STRIDE;
        end else if (r_state == S_SKIP && r_ch == 2'(n)) begin
          r_ovf[n] <= 1'b1;
        end
      end
    end
  end

  assign O_cmd_valid = (r_state == S_CMD);
  assign O_busy      = (r_state != S_IDLE);
  assign O_cmd_ch    = r_ch;
  assign O_cmd_addr  = r_addr;
  assign O_cmd_len   = LEN_W'(LINE_WORDS);
  assign O_line_pop  = (r_state == S_POP || r_state == S_SKIP) ? (4'b0001 << r_ch) : 4'b0000;
  assign O_ovf       = r_ovf;

endmodule
